// File: rtl/div21_arbiter.sv
// div21_arbiter: round-robin arbiter and sequencer sharing one 21-bit signed
// divider among NUM_REQ render-pipeline requesters.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   req[NUM_REQ]                 per-requester request, held with operands until gnt
//   req_dividend, req_divisor    packed signed operands, requester i at [21*i +: 21]
//   gnt[NUM_REQ]                 one-cycle accept pulse (operands captured)
//   rsp_valid, rsp_id            one-cycle result pulse and requester id of the result
//   rsp_quotient, rsp_err        signed quotient; err 00 ok, 01 divide-by-zero, 10 timeout
//   div_open, div_dividend,
//   div_divisor                  divider start level and operands
//   div_finish, div_quotient     divider done level and result
//   busy                         high whenever the sequencer is not idle
module div21_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*21-1:0] req_dividend,
    input  logic [NUM_REQ*21-1:0] req_divisor,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [20:0]           rsp_quotient,
    output logic [1:0]            rsp_err,
    output logic                  div_open,
    output logic [20:0]           div_dividend,
    output logic [20:0]           div_divisor,
    input  logic                  div_finish,
    input  logic [20:0]           div_quotient,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrZero    = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;

    typedef enum logic [1:0] {StIdle, StBusy, StZero, StRelease} state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [20:0]          quot_q, quot_d;
    logic [1:0]           err_q, err_d;
    logic                 open_q, open_d;
    logic [20:0]          dvd_q, dvd_d;
    logic [20:0]          dvs_q, dvs_d;

    // Round-robin search: first set req bit at or above rr_q, wrapping.
    logic                 win_found;
    logic [IDW-1:0]       win_id;
    int unsigned          idx;
    logic [NUM_REQ-1:0]   probe;
    logic [20:0]          sel_dividend;
    logic [20:0]          sel_divisor;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        probe     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx   = (32'(rr_q) + i) % NUM_REQ;
            probe = NUM_REQ'(1) << idx;
            if (!win_found && (|(req & probe))) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign sel_dividend = req_dividend[21*win_id +: 21];
    assign sel_divisor  = req_divisor[21*win_id +: 21];

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        quot_d      = quot_q;
        err_d       = err_q;
        open_d      = open_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    dvd_d = sel_dividend;
                    dvs_d = sel_divisor;
                    id_d  = win_id;
                    gnt_d = NUM_REQ'(1) << win_id;
                    rr_d  = (32'(win_id) == NUM_REQ - 1) ? '0 : win_id + IDW'(1);
                    cnt_d = '0;
                    if (sel_divisor == '0) begin
                        state_d = StZero;
                    end else begin
                        open_d  = 1'b1;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                // Finish is checked first so it wins over a coincident timeout.
                if (div_finish) begin
                    quot_d      = div_quotient;
                    err_d       = ErrOk;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    open_d      = 1'b0;
                    state_d     = StRelease;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    quot_d      = '0;
                    err_d       = ErrTimeout;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    open_d      = 1'b0;
                    state_d     = StRelease;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StZero: begin
                // Saturate toward the sign of the dividend.
                quot_d      = dvd_q[20] ? 21'h100000 : 21'h0FFFFF;
                err_d       = ErrZero;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                state_d     = StIdle;
            end
            StRelease: begin
                // Keep the divider closed until it drops finish and can re-arm.
                if (!div_finish) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            quot_q      <= '0;
            err_q       <= '0;
            open_q      <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            quot_q      <= quot_d;
            err_q       <= err_d;
            open_q      <= open_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_quotient = quot_q;
    assign rsp_err      = err_q;
    assign div_open     = open_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_div21_arbiter.sv
// tb_div21_arbiter: directed and randomized checks of div21_arbiter against a
// transaction-level reference (round-robin pick, integer division, latency rules)
// with a behavioural divider of programmable latency.
module tb_div21_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*21-1:0]  req_dividend;
    logic [NREQ*21-1:0]  req_divisor;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [20:0]         rsp_quotient;
    logic [1:0]          rsp_err;
    logic                div_open;
    logic [20:0]         div_dividend;
    logic [20:0]         div_divisor;
    logic                div_finish;
    logic [20:0]         div_quotient;
    logic                busy;

    logic signed [20:0]  op_a [NREQ];
    logic signed [20:0]  op_b [NREQ];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < NREQ; g++) begin : g_pack
        assign req_dividend[21*g +: 21] = op_a[g];
        assign req_divisor[21*g +: 21]  = op_b[g];
    end

    div21_arbiter #(
        .NUM_REQ (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_quotient (rsp_quotient),
        .rsp_err      (rsp_err),
        .div_open     (div_open),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_finish   (div_finish),
        .div_quotient (div_quotient),
        .busy         (busy)
    );

    // Divider model: finish rises 'lat' cycles after open, drops once open drops.
    int          lat = 1;
    bit          hang = 1'b0;
    bit          fin_force = 1'b0;
    int          dcnt;
    logic        fin_r;
    logic [20:0] dq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt  <= 0;
            fin_r <= 1'b0;
            dq    <= '0;
        end else if (!div_open) begin
            dcnt  <= 0;
            fin_r <= 1'b0;
        end else if (!fin_r && !hang) begin
            dcnt <= dcnt + 1;
            if (dcnt + 1 >= lat) begin
                fin_r <= 1'b1;
                dq    <= 21'($signed(div_dividend) / $signed(div_divisor));
            end
        end
    end

    assign div_finish   = fin_r | fin_force;
    assign div_quotient = dq;

    int n_vec = 0;
    int n_err = 0;
    int rr_m  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return 0;
    endfunction

    // One full transaction: request, grant, response, return to idle.
    task automatic do_op(input logic [NREQ-1:0] r, input int l, input bit hng,
                         input bit keep, input int stall);
        int           w, c, extra, cnt2, ecyc;
        bit           seen;
        logic [3:0]   eg;
        logic [20:0]  ea, eb, eq;
        logic [1:0]   ee;
        lat  = l;
        hang = hng;
        req  = r;
        w    = pick(r, rr_m);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                seen = 1'b1;
                break;
            end
        end
        check("gnt_seen", 32'(seen), 32'd1);
        if (!seen) begin
            req = '0;
            return;
        end
        eg = 4'b0001 << w;
        check("gnt", 32'(gnt), 32'(eg));
        rr_m = (w + 1) % NREQ;
        ea = op_a[w];
        eb = op_b[w];
        if (eb == '0) begin
            eq = ea[20] ? 21'h100000 : 21'h0FFFFF;
            ee = 2'b01;
            ecyc = 1;
        end else if (hng) begin
            eq = '0;
            ee = 2'b10;
            ecyc = TMO;
        end else begin
            eq = 21'(int'(op_a[w]) / int'(op_b[w]));
            ee = 2'b00;
            ecyc = l + 1;
        end
        check("open_at_gnt", 32'(div_open), 32'(eb != '0));
        if (eb != '0) begin
            check("div_dividend", 32'(div_dividend), 32'(ea));
            check("div_divisor", 32'(div_divisor), 32'(eb));
        end
        if (!keep) begin
            req     = '0;
            op_a[w] = 21'($urandom);
            op_b[w] = 21'($urandom);
        end
        c = 0; extra = 0; cnt2 = 0; seen = 1'b0;
        for (int i = 0; i < TMO + 20; i++) begin
            @(negedge clk);
            c++;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (gnt != '0) extra++;
            if (div_open) cnt2++;
        end
        check("rsp_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check("latency", 32'(c), 32'(ecyc));
        check("rsp_id", 32'(rsp_id), 32'(w));
        check("rsp_quotient", 32'(rsp_quotient), 32'(eq));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        check("gnt_extra", 32'(extra), 32'd0);
        if (eb == '0) check("open_never", 32'(cnt2), 32'd0);
        fin_force = (stall > 0);
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        extra = 0; cnt2 = 0;
        if (stall > 0) begin
            if (!busy) cnt2++;
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                if (!busy) cnt2++;
                if (gnt != '0) extra++;
            end
            fin_force = 1'b0;
            check("release_hold", 32'(cnt2), 32'd0);
            check("release_gnt", 32'(extra), 32'd0);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!busy) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("back_idle", 32'(seen), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        logic [127:0] v;
        v = {gnt, rsp_valid, rsp_id, rsp_quotient, rsp_err, div_open, div_dividend,
             div_divisor, busy};
        check(tag, 32'(v[63:0] != '0), 32'd0);
    endtask

    initial begin
        int cnt;
        int v;
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = 21'sd1;
        end
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        check("reset_quotient", 32'(rsp_quotient), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request 100/7.
        op_a[0] = 21'sd100; op_b[0] = 21'sd7;
        do_op(4'b0001, 3, 1'b0, 1'b0, 0);
        // Divide-by-zero, both signs.
        op_a[1] = 21'sd1;  op_b[1] = 21'sd0;
        do_op(4'b0010, 1, 1'b0, 1'b0, 0);
        op_a[2] = -21'sd1; op_b[2] = 21'sd0;
        do_op(4'b0100, 1, 1'b0, 1'b0, 0);
        // Negative operands truncate toward zero.
        op_a[3] = -21'sd21; op_b[3] = 21'sd4;
        do_op(4'b1000, 2, 1'b0, 1'b0, 0);

        // Contention with all requests held: 0,1,2,3.
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 21'(100 * (i + 1) + 3);
            op_b[i] = 21'sd7;
        end
        for (int i = 0; i < NREQ; i++) do_op(4'b1111, 2, 1'b0, 1'b1, 0);
        do_op(4'b0001, 1, 1'b0, 1'b0, 0);
        op_a[0] = 21'sd700; op_b[0] = 21'sd7;
        op_a[3] = 21'sd770; op_b[3] = 21'sd7;
        do_op(4'b1001, 4, 1'b0, 1'b1, 0);
        do_op(4'b1001, 4, 1'b0, 1'b1, 0);

        // Timeout, then finish held high keeps the arbiter in release.
        op_a[2] = 21'sd50; op_b[2] = 21'sd3;
        do_op(4'b0100, 1, 1'b1, 1'b1, 5);
        do_op(4'b0010, 2, 1'b0, 1'b0, 0);

        // Reset in the middle of a busy operation.
        op_a[0] = 21'sd9; op_b[0] = 21'sd2;
        lat = 1; hang = 1'b1; req = 4'b0001;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != '0) break;
        end
        check("pre_reset_open", 32'(div_open), 32'd1);
        req = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midreset_outputs");
        check("midreset_quotient", 32'(rsp_quotient), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hang = 1'b0;
        rr_m = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("aborted_no_rsp", 32'(cnt), 32'd0);
        op_a[1] = 21'sd40; op_b[1] = 21'sd5;
        op_a[0] = 21'sd30; op_b[0] = 21'sd5;
        do_op(4'b1111, 2, 1'b0, 1'b0, 0);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                v = int'($urandom_range(0, 1000000)) - 500000;
                op_a[i] = 21'(v);
                if ($urandom_range(0, 4) == 0) begin
                    op_b[i] = '0;
                end else begin
                    v = int'($urandom_range(1, 2000));
                    if ($urandom_range(0, 1) == 1) v = -v;
                    op_b[i] = 21'(v);
                end
            end
            do_op(4'($urandom_range(1, 15)), int'($urandom_range(1, 6)), 1'b0, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div21_arbiter.md
Name: div21_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one divider_21bits instance among NUM_REQ render-pipeline requesters (edge-slope and perspective-divide stages).
- Accepts one signed 21-bit divide request at a time and drives the divider's open/dividend/divisor inputs.
- Waits for finish, then returns the quotient tagged with the requester id.
- Intercepts divide-by-zero and guards against a hung divider with a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must satisfy 2^IDW >= NUM_REQ.
- TIMEOUT, 64, max cycles in BUSY before the divide is abandoned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held with operands until its gnt.
- req_dividend  input  NUM_REQ*21  packed signed dividends; requester i occupies bits [21*i+20:21*i].
- req_divisor  input  NUM_REQ*21  packed signed divisors, same packing.
- gnt  output  NUM_REQ  one-cycle accept pulse; operands have been captured.
- rsp_valid  output  1  one-cycle result pulse.
- rsp_id  output  IDW  requester id of the result.
- rsp_quotient  output  21  signed quotient.
- rsp_err  output  2  00 ok, 01 divide-by-zero, 10 timeout.
- div_open  output  1  divider start/enable level.
- div_dividend  output  21  operand to divider.
- div_divisor  output  21  operand to divider.
- div_finish  input  1  divider done level.
- div_quotient  input  21  divider result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; rr_ptr=0; all outputs 0; timeout counter 0; any in-flight operation is dropped with no response.
- States: IDLE, BUSY, ZERO, RELEASE.
- IDLE:
  - On a clock edge where any req bit is high, select the first set bit, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - Capture the winner's operands into div_dividend/div_divisor and its id.
  - Assert that gnt bit for exactly the next cycle.
  - Set rr_ptr = winner+1 (wrap).
  - If the captured divisor==0, go to ZERO; otherwise set div_open=1 and go to BUSY.
- BUSY:
  - div_open held 1; counter increments every cycle.
  - When div_finish is sampled 1: register div_quotient into rsp_quotient, rsp_err=00, pulse rsp_valid next cycle, div_open=0, go to RELEASE.
  - When the counter reaches TIMEOUT-1 without finish: rsp_quotient=0, rsp_err=10, pulse rsp_valid, div_open=0, go to RELEASE.
  - If finish and timeout coincide, finish wins.
- ZERO (one cycle):
  - Divider is never opened.
  - rsp_valid pulse with rsp_err=01.
  - rsp_quotient = 21'h0FFFFF if dividend >= 0, else 21'h100000.
  - Return to IDLE.
- RELEASE:
  - div_open held 0 until div_finish is sampled 0, so the divider re-arms; then go to IDLE.
  - A new request can be granted no earlier than the cycle after re-entering IDLE.
- Latency:
  - Nonzero divisor: grant to rsp_valid = divider latency + 1 cycle.
  - Zero divisor: grant to rsp_valid = 1 cycle.
- Operand stability:
  - div_dividend/div_divisor stay stable from grant until leaving BUSY.
  - The requester may change its operands after gnt.
- rsp_id/rsp_quotient/rsp_err hold their last values between pulses.
- req bits that drop before grant are simply not served; no error.
- gnt is one-hot or zero; at most one grant per operation.

Test Plan:
- Single request: req[0], dividend=100, divisor=7 -> gnt[0] one cycle; div_open high until finish; rsp_valid with id 0, quotient 14, err 00; then div_open low and state back to IDLE.
- Contention: req=4'b1111 held, each requester with a distinct dividend/7 -> grants in order 0,1,2,3; then with rr_ptr=1 and req=4'b1001 held -> grants 3 then 0; every rsp_id matches its operands.
- Divide-by-zero: dividend=1, divisor=0 -> div_open never asserted; rsp_valid 1 cycle after gnt with quotient 21'h0FFFFF, err 01. Dividend=-1, divisor=0 -> quotient 21'h100000.
- Negative operands: -21/4 -> quotient 21'h1FFFFB (-5, truncation toward zero), err 00.
- Timeout: divider model never asserts finish -> after TIMEOUT cycles, rsp_valid with quotient 0, err 10; arbiter stays in RELEASE until finish is low, then grants the next request.
- Reset mid-BUSY: assert rst between clock edges -> all outputs 0 immediately; no rsp_valid for the aborted operation; first request after release of reset goes to requester 0.
